// File: rtl/vit_pkg.sv
// Shared constants for the 4-state (K=3, r=2) Viterbi path-metric sequencer:
// code geometry, metric packing helpers and the controller state encoding.
package vit_pkg;

  localparam int K        = 3;
  localparam int R        = 2;
  localparam int NS       = 1 << (K - 1);
  localparam int MW       = 8;
  localparam int INIT_PEN = 64;
  localparam int MET_W    = NS * MW;

  // Controller states, kept as plain 3-bit constants for legacy tools.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_WAIT_SYM = 3'd1;
  localparam state_t S_ACS      = 3'd2;
  localparam state_t S_UPD      = 3'd3;
  localparam state_t S_TB       = 3'd4;
  localparam state_t S_TB_WAIT  = 3'd5;

  // State i's metric occupies [met_lsb(i) +: MW] of a packed metric vector.
  function automatic int met_lsb(input int i);
    return MW * i;
  endfunction

  // Frame-start metrics: state 0 is the known encoder start, all others penalised.
  function automatic logic [MET_W-1:0] init_metrics();
    logic [MET_W-1:0] v;
    v = '0;
    for (int i = 1; i < NS; i++) v[met_lsb(i) +: MW] = MW'(INIT_PEN);
    return v;
  endfunction

  localparam logic [MET_W-1:0] INIT_MET = init_metrics();

endpackage

// File: rtl/vit_norm.sv
// Path-metric normalizer. With VIT_NORM_EN defined, when every metric has its
// MSB set, 2^(MW-1) is subtracted from all of them (ordering is preserved);
// otherwise, and always when VIT_NORM_EN is undefined, metrics pass unchanged.
module vit_norm
  import vit_pkg::*;
(
  input  logic [MET_W-1:0] met_in,
  output logic [MET_W-1:0] met_out
);

`ifdef VIT_NORM_EN
  logic all_high;

  // Clear the common MSB only when no metric could underflow.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a signal unassigned (no latch).
    all_high = 1'b1;
    met_out  = met_in;
    for (int i = 0; i < NS; i++) all_high = all_high & met_in[met_lsb(i) + MW - 1];
    if (all_high) begin
      for (int i = 0; i < NS; i++) met_out[met_lsb(i) + MW - 1] = 1'b0;
    end
  end
`else
  assign met_out = met_in;
`endif

endmodule

// File: rtl/viterbi_acs_ctrl.sv
// Sequencer for the 4-state path-metric unit: loads initial metrics, paces one
// received symbol per ACS step, captures/normalises returned metrics, strobes
// survivor writes and hands off to traceback at frame end.
// Optional feature: VIT_NORM_EN enables metric normalisation (see vit_norm).
module viterbi_acs_ctrl
  import vit_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int AW        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic [R-1:0]     sym_data,
  output logic [R-1:0]     sym_q,
  output logic [MET_W-1:0] pmu_dis,
  input  logic [MET_W-1:0] pmu_dis_in,
  output logic             surv_we,
  output logic [AW-1:0]    surv_addr,
  output logic             tb_start,
  output logic [AW-1:0]    tb_addr,
  input  logic             tb_done,
  output logic             busy,
  output logic             frame_done
);

  // One spare bit so the counter can hold FRAME_LEN itself when FRAME_LEN == 2^AW.
  localparam int CW = AW + 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    sym_cnt_q, sym_cnt_d;
  logic             sym_ready_q, sym_ready_d;
  logic [R-1:0]     sym_q_q, sym_q_d;
  logic [MET_W-1:0] pmu_dis_q, pmu_dis_d;
  logic             surv_we_q, surv_we_d;
  logic [AW-1:0]    surv_addr_q, surv_addr_d;
  logic             tb_start_q, tb_start_d;
  logic [AW-1:0]    tb_addr_q, tb_addr_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic [MET_W-1:0] norm_met;

  vit_norm u_norm (
    .met_in  (pmu_dis_in),
    .met_out (norm_met)
  );

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_d      = state_q;
    sym_cnt_d    = sym_cnt_q;
    sym_ready_d  = sym_ready_q;
    sym_q_d      = sym_q_q;
    pmu_dis_d    = pmu_dis_q;
    surv_we_d    = 1'b0;
    surv_addr_d  = surv_addr_q;
    tb_start_d   = 1'b0;
    tb_addr_d    = tb_addr_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pmu_dis_d   = INIT_MET;
          sym_cnt_d   = '0;
          sym_ready_d = 1'b1;
          state_d     = S_WAIT_SYM;
        end
      end
      S_WAIT_SYM: begin
        if (sym_valid && sym_ready_q) begin
          sym_q_d     = sym_data;
          sym_ready_d = 1'b0;
          state_d     = S_ACS;
        end
      end
      S_ACS: begin
        // PMU latches its results at the end of this cycle; write them next.
        surv_we_d   = 1'b1;
        surv_addr_d = sym_cnt_q[AW-1:0];
        state_d     = S_UPD;
      end
      S_UPD: begin
        pmu_dis_d = norm_met;
        sym_cnt_d = sym_cnt_q + CW'(1);
        if (sym_cnt_q == CW'(FRAME_LEN - 1)) begin
          tb_start_d = 1'b1;
          tb_addr_d  = AW'(FRAME_LEN - 1);
          state_d    = S_TB;
        end else begin
          sym_ready_d = 1'b1;
          state_d     = S_WAIT_SYM;
        end
      end
      S_TB: begin
        // tb_done is deliberately not looked at in the start cycle.
        state_d = S_TB_WAIT;
      end
      S_TB_WAIT: begin
        if (tb_done) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; asynchronous reset abandons any frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      sym_cnt_q    <= '0;
      sym_ready_q  <= 1'b0;
      sym_q_q      <= '0;
      pmu_dis_q    <= '0;
      surv_we_q    <= 1'b0;
      surv_addr_q  <= '0;
      tb_start_q   <= 1'b0;
      tb_addr_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking '<=' so every flop samples the
      // pre-edge values regardless of statement order.
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      sym_ready_q  <= sym_ready_d;
      sym_q_q      <= sym_q_d;
      pmu_dis_q    <= pmu_dis_d;
      surv_we_q    <= surv_we_d;
      surv_addr_q  <= surv_addr_d;
      tb_start_q   <= tb_start_d;
      tb_addr_q    <= tb_addr_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sym_ready  = sym_ready_q;
  assign sym_q      = sym_q_q;
  assign pmu_dis    = pmu_dis_q;
  assign surv_we    = surv_we_q;
  assign surv_addr  = surv_addr_q;
  assign tb_start   = tb_start_q;
  assign tb_addr    = tb_addr_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/viterbi_acs_ctrl.md
Name: viterbi_acs_ctrl

Overview:
- Sequencer for the 4-state (K=3, r=2) path-metric unit.
- Per frame, it loads initial metrics and accepts one received symbol per step.
- Each step, it presents the symbol to the branch-metric logic, lets the PMU run one ACS step, captures and normalizes the new metrics, and writes survivor decisions.
- After FRAME_LEN symbols, it hands off to traceback and reports frame completion.

Parameters:
- K, 3, constraint length; NS = 1<<(K-1) = 4 states.
- R, 2, code bits per symbol.
- MW, 8, path-metric width per state.
- FRAME_LEN, 16, symbols per frame, range 2..(1<<AW).
- AW, 4, survivor-memory address width.
- INIT_PEN, 64, initial metric for states 1..NS-1; state 0 starts at 0.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin frame; sampled only in IDLE.
- sym_valid  in  1  received symbol valid.
- sym_ready  out  1  controller can accept a symbol.
- sym_data  in  R  received code bits.
- sym_q  out  R  registered symbol driven to the branch-metric logic.
- pmu_dis  out  NS*MW  current metrics to PMU; state i occupies [MW*(i+1)-1:MW*i].
- pmu_dis_in  in  NS*MW  registered metrics returned by the PMU.
- surv_we  out  1  survivor-memory write strobe; data is the PMU path_out.
- surv_addr  out  AW  survivor write address.
- tb_start  out  1  one-cycle traceback start pulse.
- tb_addr  out  AW  traceback start address.
- tb_done  in  1  traceback complete.
- busy  out  1  high whenever state is not IDLE.
- frame_done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. Every output and register is 0: sym_ready, sym_q, pmu_dis, surv_we, surv_addr, tb_start, tb_addr, busy, frame_done, sym_cnt. Reset mid-frame abandons the frame with no frame_done.
- FSM states: IDLE, WAIT_SYM, ACS, UPD, TB, TB_WAIT.
- IDLE:
  - start=1 loads pmu_dis = {INIT_PEN x3, 0}, sets sym_cnt=0, goes to WAIT_SYM.
  - start in any other state is ignored.
- WAIT_SYM:
  - sym_ready=1 (registered, asserted on entry).
  - sym_valid&sym_ready captures sym_q<=sym_data, deasserts sym_ready, goes to ACS.
  - sym_valid without ready has no effect.
- ACS (1 cycle): sym_q and pmu_dis are stable; the PMU latches its results at the end of this cycle.
- UPD (1 cycle):
  - surv_we=1 with surv_addr=sym_cnt.
  - pmu_dis <= norm(pmu_dis_in).
  - sym_cnt increments.
  - If sym_cnt was FRAME_LEN-1, go to TB; else go to WAIT_SYM.
- TB (1 cycle): tb_start=1, tb_addr=FRAME_LEN-1, then go to TB_WAIT.
- TB_WAIT:
  - Waits for tb_done. On tb_done, frame_done pulses for 1 cycle and the FSM goes to IDLE.
  - tb_done in other states is ignored.
  - tb_done in the same cycle as TB entry is not observed.
- Throughput: at most 1 symbol per 3 cycles. Latency from symbol accept to survivor write is 2 cycles.
- surv_addr wraps modulo 1<<AW; with FRAME_LEN = 1<<AW, the last write is at the all-ones address.
- Metric arithmetic is unsigned MW-bit.

Optional Feature:
- Macro: VIT_NORM_EN.
- Defined:
  - norm() checks bit MW-1 of all NS metrics.
  - If all are set, bit MW-1 is cleared in every metric (subtract 1<<(MW-1)); otherwise metrics pass unchanged.
  - Relative ordering of the metrics is preserved.
- Undefined:
  - norm() is identity.
  - Integrators must guarantee INIT_PEN + FRAME_LEN*R < 1<<MW so that no wrap occurs.

Decomposition:
- Package vit_pkg:
  - K, R, NS, MW, INIT_PEN defaults.
  - FSM state enum with 3-bit encoding.
  - Metric slice-index helper constants.
- Sub-module vit_norm: combinational NS*MW-in / NS*MW-out normalizer; the only place VIT_NORM_EN is tested.

Test Plan:
- Reset mid-frame:
  - Stimulus: rst low during UPD of symbol 5.
  - Required: all outputs 0, IDLE; a new start runs a full frame; sym_cnt restarts at 0.
- Start and init metrics:
  - Stimulus: start=1 in IDLE.
  - Required: next cycle pmu_dis=32'h40404000, sym_ready=1, busy=1.
- Handshake and write strobe:
  - Stimulus: sym_valid held low 3 cycles, then sym_data=2'b10.
  - Required: sym_q=2'b10; surv_we high exactly 2 cycles after accept with surv_addr=0; sym_ready low during ACS and UPD.
- Full frame of 16 symbols:
  - Required: surv_we addresses 0..15; tb_start pulse with tb_addr=15.
  - Then tb_done after 7 cycles: frame_done pulses 1 cycle and the controller returns to IDLE.
- Normalization (VIT_NORM_EN defined):
  - Stimulus: pmu_dis_in=32'h8C_90_A0_81 in UPD.
  - Required: pmu_dis=32'h0C_10_20_01.
  - With pmu_dis_in=32'h7F_90_A0_81: pmu_dis is unchanged. Without the macro, both cases are unchanged.
- Spurious inputs:
  - Stimulus: start during WAIT_SYM, and tb_done during ACS.
  - Required: no state change, no frame_done.
